// File: rtl/ahb_lite_memory_responder_pkg.sv
// Shared types and widths for the AHB-lite memory responder.
package ahb_lite_memory_responder_pkg;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/ahb_lite_memory_responder_sram.sv
// Single-port DEPTH x 32 array, synchronous read and byte-masked write, no reset.
module ahb_lite_memory_responder_sram
   import ahb_lite_memory_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [LANES-1:0]  be,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];

   // Read port only updates on a read, so rdata holds the last read word.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < LANES; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end
endmodule

// File: rtl/ahb_lite_memory_responder.sv
// Memory-side responder: latches one word request, counts wait states, pulses BusReady.
// Optional same-block fast path: define AHB_LITE_MEMORY_RESPONDER_PAGE_MODE_EN.
//
// state | meaning
// IDLE  | waiting for HRequest; sampling edge latches the request and loads the counter
// WAIT  | counting down wait states; HRequest low aborts
// RESP  | BusReady high for one cycle, then back to IDLE
module ahb_lite_memory_responder
   import ahb_lite_memory_responder_pkg::*;
#(
   parameter int DEPTH      = 1024,
   parameter int WAITSTATES = 2,
   parameter int PAGEWAIT   = 0,
   parameter int BLOCKSIZE  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              HRequest,
   input  logic              HWrite,
   input  logic [31:0]       HAddr,
   input  logic [WORD_W-1:0] HWData,
   input  logic [LANES-1:0]  HByteMask,
   output logic [WORD_W-1:0] HRData,
   output logic              BusReady
);
   localparam int IDXBITS = $clog2(DEPTH);
   localparam int OFFBITS = $clog2(BLOCKSIZE);
   localparam int TAGW    = 30 - OFFBITS;
   localparam logic [15:0] WS_LD = 16'(WAITSTATES);
   localparam logic [15:0] PW_LD = 16'(PAGEWAIT);

   state_t              state, state_n;
   logic [15:0]         cnt, cnt_n, ld_val;
   logic                commit;
   logic [IDXBITS-1:0]  req_idx;
   logic                req_write;
   logic [WORD_W-1:0]   req_wdata;
   logic [LANES-1:0]    req_mask;
   logic                rd_seen;
   logic [IDXBITS-1:0]  mem_addr;
   logic                mem_we;
   logic [WORD_W-1:0]   mem_wdata, mem_rdata;
   logic [LANES-1:0]    mem_be;
   logic                unused_ok;

   assign unused_ok = ^{HAddr[31:IDXBITS+2], HAddr[1:0]};

`ifdef AHB_LITE_MEMORY_RESPONDER_PAGE_MODE_EN
   logic [TAGW-1:0] addr_tag, tag, req_tag;
   logic            tag_vld;

   assign addr_tag = HAddr[31:2+OFFBITS];

   // Tag only moves on a commit, so aborted requests never touch it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag     <= '0;
         req_tag <= '0;
         tag_vld <= 1'b0;
      end else begin
         if (state == IDLE && HRequest) req_tag <= addr_tag;
         if (commit) begin
            tag     <= (state == IDLE) ? addr_tag : req_tag;
            tag_vld <= 1'b1;
         end
      end
   end
`endif

   always_comb begin
      ld_val = WS_LD;
`ifdef AHB_LITE_MEMORY_RESPONDER_PAGE_MODE_EN
      if (tag_vld && (addr_tag == tag)) ld_val = PW_LD;
`endif
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            if (HRequest) begin
               cnt_n = ld_val;
               if (ld_val == 16'd0) begin
                  state_n = RESP;
                  commit  = 1'b1;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (!HRequest) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - 16'd1;
               if (cnt == 16'd1) begin
                  state_n = RESP;
                  commit  = 1'b1;
               end
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_idx   <= '0;
         req_write <= 1'b0;
         req_wdata <= '0;
         req_mask  <= '0;
         rd_seen   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == IDLE && HRequest) begin
            req_idx   <= HAddr[IDXBITS+1:2];
            req_write <= HWrite;
            req_wdata <= HWData;
            req_mask  <= HByteMask;
         end
         if (commit && !mem_we) rd_seen <= 1'b1;
      end
   end

   // A zero-wait commit happens on the sampling edge itself, so use the live bus then.
   always_comb begin
      if (state == IDLE) begin
         mem_addr  = HAddr[IDXBITS+1:2];
         mem_we    = HWrite;
         mem_wdata = HWData;
         mem_be    = HByteMask;
      end else begin
         mem_addr  = req_idx;
         mem_we    = req_write;
         mem_wdata = req_wdata;
         mem_be    = req_mask;
      end
   end

   ahb_lite_memory_responder_sram #(.DEPTH(DEPTH)) u_sram (
      .clk   (clk),
      .en    (commit),
      .we    (mem_we),
      .be    (mem_be),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // The array has no reset, so read data is masked to zero until the first read lands.
   assign HRData   = rd_seen ? mem_rdata : '0;
   assign BusReady = (state == RESP);
endmodule

// File: tb/tb_ahb_lite_memory_responder.sv
// Scoreboard bench for ahb_lite_memory_responder (main instance WAITSTATES=2, second instance WAITSTATES=0).
`timescale 1ns/1ps
module tb_ahb_lite_memory_responder;
   localparam int WS = 2;
   localparam int PW = 0;

   logic        clk = 1'b0, reset = 1'b0;
   logic        HRequest = 1'b0, HRequest0 = 1'b0, HWrite = 1'b0;
   logic [31:0] HAddr = '0, HWData = '0;
   logic [3:0]  HByteMask = '0;
   logic [31:0] HRData, HRData0;
   logic        BusReady, BusReady0;

   int tests = 0, fails = 0, cyc = 0, n_rdy = 0, last_rdy = 0;

   typedef struct {
      string       name;
      logic        chk;
      logic [31:0] data;
      int          edges;
      int          start;
   } exp_t;
   exp_t sb[$];

`ifdef AHB_LITE_MEMORY_RESPONDER_PAGE_MODE_EN
   logic [27:0] m_tag = '0;
   logic        m_vld = 1'b0;
`endif

   ahb_lite_memory_responder #(.DEPTH(1024), .WAITSTATES(WS), .PAGEWAIT(PW), .BLOCKSIZE(4)) u_dut (
      .clk(clk), .reset(reset), .HRequest(HRequest), .HWrite(HWrite), .HAddr(HAddr),
      .HWData(HWData), .HByteMask(HByteMask), .HRData(HRData), .BusReady(BusReady));

   ahb_lite_memory_responder #(.DEPTH(1024), .WAITSTATES(0), .PAGEWAIT(0), .BLOCKSIZE(4)) u_dut0 (
      .clk(clk), .reset(reset), .HRequest(HRequest0), .HWrite(HWrite), .HAddr(HAddr),
      .HWData(HWData), .HByteMask(HByteMask), .HRData(HRData0), .BusReady(BusReady0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Edges from the sampling edge to BusReady inclusive, from a tiny page-tag model.
   function automatic int exp_edges(input logic [31:0] a);
`ifdef AHB_LITE_MEMORY_RESPONDER_PAGE_MODE_EN
      if (m_vld && a[31:4] == m_tag) return PW + 1;
`endif
      return WS + 1;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (reset === 1'b1 && BusReady === 1'b1) begin
         n_rdy++;
         last_rdy = cyc;
         if (sb.size() == 0) begin
            check("spurious_busready", {31'b0, BusReady}, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.edges));
            if (e.chk) check({e.name, "_rdata"}, HRData, e.data);
         end
      end
   end

   task automatic issue(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic chk_rd, input logic [31:0] exp_rd);
      int edges;
      bit got;
      edges = exp_edges(a);
      HRequest = 1'b1; HWrite = w; HAddr = a; HWData = d; HByteMask = m;
      sb.push_back('{name, chk_rd, exp_rd, edges, cyc});
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         if (BusReady) got = 1'b1;
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL %s_timeout: no BusReady in 40 cycles, expected after %0d edges", name, edges);
      end
`ifdef AHB_LITE_MEMORY_RESPONDER_PAGE_MODE_EN
      else begin
         m_tag = a[31:4];
         m_vld = 1'b1;
      end
`endif
      @(posedge clk); #1;
      HRequest = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int s0, r0, exp_total;
      #2;
      check("reset_busready", {31'b0, BusReady}, 32'd0);
      check("reset_hrdata", HRData, 32'd0);
      #20 reset = 1'b1;
      @(posedge clk); #1;

      issue("wr_full", 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
      issue("rd_full", 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
      issue("wr_byte1", 1'b1, 32'h100, 32'h0000AB00, 4'b0010, 1'b0, 32'h0);
      issue("rd_byte1", 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADABEF);
      issue("wr_mask0", 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
      issue("rd_mask0", 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADABEF);

      for (int i = 0; i < 4; i++)
         issue("blk_pre", 1'b1, 32'h200 + 32'(4*i), 32'(i+1), 4'hF, 1'b0, 32'h0);
      s0 = cyc; r0 = n_rdy; exp_total = 0;
      for (int i = 0; i < 4; i++) begin
         exp_total += exp_edges(32'h200 + 32'(4*i)) + 1;
         issue("blk_rd", 1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0, 1'b1, 32'(i+1));
      end
      check("blk_total_cycles", 32'(last_rdy + 1 - s0), 32'(exp_total));
      idle(4);
      check("blk_pulses", 32'(n_rdy - r0), 32'd4);

      // Abort on the last WAIT cycle: no pulse, no write.
      r0 = n_rdy;
      HRequest = 1'b1; HWrite = 1'b1; HAddr = 32'h100; HWData = 32'hCAFEF00D; HByteMask = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      HRequest = 1'b0;
      idle(6);
      check("abort_pulses", 32'(n_rdy - r0), 32'd0);
      issue("abort_rd", 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADABEF);

      // Reset mid-WAIT on a write to 0x200.
      HRequest = 1'b1; HWrite = 1'b1; HAddr = 32'h200; HWData = 32'h12345678; HByteMask = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("rst_mid_busready", {31'b0, BusReady}, 32'd0);
      check("rst_mid_hrdata", HRData, 32'd0);
      HRequest = 1'b0;
`ifdef AHB_LITE_MEMORY_RESPONDER_PAGE_MODE_EN
      m_vld = 1'b0;
`endif
      @(posedge clk); #3;
      reset = 1'b1;
      @(posedge clk); #1;
      issue("rst_rd_100", 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADABEF);
      issue("rst_rd_200", 1'b0, 32'h200, 32'h0, 4'h0, 1'b1, 32'h1);

      issue("alias_wr", 1'b1, 32'h0000_0004, 32'h11, 4'hF, 1'b0, 32'h0);
      issue("alias_rd", 1'b0, 32'h0000_1004, 32'h0, 4'h0, 1'b1, 32'h11);

      issue("pg_300", 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 32'h0);
      issue("pg_304", 1'b0, 32'h304, 32'h0, 4'h0, 1'b0, 32'h0);
      issue("pg_310", 1'b0, 32'h310, 32'h0, 4'h0, 1'b0, 32'h0);

      // Zero-wait instance; request held through RESP must not be re-accepted.
      HRequest0 = 1'b1; HWrite = 1'b1; HAddr = 32'h8; HWData = 32'h55; HByteMask = 4'hF;
      @(posedge clk); #1;
      check("zw_wr_ready", {31'b0, BusReady0}, 32'd1);
      @(posedge clk); #1;
      check("zw_no_reaccept", {31'b0, BusReady0}, 32'd0);
      HRequest0 = 1'b0;
      @(posedge clk); #1;
      check("zw_idle", {31'b0, BusReady0}, 32'd0);
      HRequest0 = 1'b1; HWrite = 1'b0;
      @(posedge clk); #1;
      check("zw_rd_ready", {31'b0, BusReady0}, 32'd1);
      check("zw_rd_data", HRData0, 32'h55);
      HRequest0 = 1'b0;
      idle(3);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
